param_dp_ram: RTL and testbench
===============================

Name: param_dp_ram

Overview:
Parametrised simple dual-port RAM with one write port and one read port on a single clock.
- Supports simultaneous read and write in the same cycle.
- Read-during-write mode, read latency and data/address widths are configurable.
- A hardware clear sequencer initialises every entry after reset.
- Storage block for buffer and FIFO-style datapaths; general-purpose replacement for the fixed 16x8 RAM.

Parameters:
- DATA_W, 8, data width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2. Value 2 adds an output register.
- WRITE_FIRST, 0, same-address read/write collision result: 1 returns new write data, 0 returns old memory contents.
- CLEAR_VAL, 0, value written to every entry by the clear sequencer. Width DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  chip select; gates both ports.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data; holds its last value between reads.
- rd_valid  out  1  one-cycle pulse marking new rd_data.
- collision  out  1  pulse aligned with rd_valid; set when the read hit the address written in the same cycle.
- busy  out  1  high while clearing; user ops are ignored while it is high.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, collision=0, busy=1, pipeline valid bits=0.
- FSM states are CLEAR and READY.
- While reset is high:
  - state=CLEAR, clr_addr=0.
  - No memory writes occur.
- CLEAR state, after reset drops:
  - Each cycle writes CLEAR_VAL to mem[clr_addr] and increments clr_addr.
  - After the write at clr_addr=DEPTH-1, go to READY and deassert busy on the next edge.
  - busy is high for exactly DEPTH cycles after reset deasserts.
  - All DEPTH entries are cleared, including the last.
- Reset asserted mid-clear restarts the clear at address 0. Reset in READY re-enters CLEAR.
- While busy=1:
  - cs/wr_en/rd_en are ignored: no write, no rd_valid.
  - Requests are dropped, not queued.
- READY, write: cs&wr_en writes wr_data to mem[wr_addr] at the clock edge.
- READY, read: cs&rd_en samples mem[rd_addr].
  - RD_LAT=1: rd_data/rd_valid update at the same edge (data visible the cycle after the request).
  - RD_LAT=2: one more register stage.
- Read and write are independent; both may fire in the same cycle. There is no priority between them.
- Back-to-back reads are allowed every cycle at full throughput for either RD_LAT.
- Collision (same cycle, cs&wr_en&rd_en, wr_addr==rd_addr):
  - The write always happens.
  - Read returns wr_data if WRITE_FIRST=1, else the prior mem contents.
  - collision=1 with that rd_valid.
- cs=0: no operation; outputs hold except rd_valid/collision, which fall to 0 once the pipeline drains.
- Addresses are full-range (DEPTH = 2**ADDR_W), so out-of-range addresses cannot occur.
- RD_LAT outside {1,2} is a elaboration-time error.

Decomposition:
- Shared package param_dp_ram_pkg holds:
  - FSM state enum (ST_CLEAR, ST_READY).
  - Constants RD_LAT_MIN=1, RD_LAT_MAX=2.
- One sub-module, dp_ram_rd_pipe: parametrised by DATA_W and RD_LAT. Carries data/valid/collision through 1 or 2 stages with synchronous reset of the valid bits.
- Memory array, clear FSM and collision compare stay in the top module.

Test Plan:
- Clear after reset:
  - Stimulus: reset 3 cycles, then release; DEPTH=16, CLEAR_VAL=8'hA5.
  - Required: busy high exactly 16 cycles. Reads of addr 0..15 all return 8'hA5, including addr 15.
- Ops ignored during clear:
  - Stimulus: while busy, write 8'h3C to addr 2 and read addr 2.
  - Required: no rd_valid. After busy falls, a read of addr 2 returns CLEAR_VAL.
- Simultaneous independent ports:
  - Stimulus: same cycle, write 8'h11 to addr 4 and read addr 7 (holding 8'h77).
  - Required: rd_data=8'h77 with rd_valid=1 and collision=0. A later read of addr 4 returns 8'h11.
- Collision both modes:
  - Stimulus: addr 5 holds 8'h55; same cycle, write 8'h99 and read addr 5.
  - Required: WRITE_FIRST=0 returns 8'h55; WRITE_FIRST=1 returns 8'h99. collision=1 in both. mem[5]=8'h99 afterwards.
- Reset mid-clear:
  - Stimulus: assert reset for 1 cycle at clear cycle 9.
  - Required: clear restarts at 0 and busy stays high for 16 more cycles. All entries read CLEAR_VAL.
- Latency and throughput at RD_LAT=2:
  - Stimulus: reads of addr 0,1,2 on consecutive cycles.
  - Required: rd_valid high 3 consecutive cycles starting 2 cycles after the first request, with data in request order. rd_data holds the addr-2 value afterwards.

Source files
------------

// File: rtl/param_dp_ram_pkg.sv
// param_dp_ram_pkg
// Shared definitions for the param_dp_ram storage block: the clear/ready
// state encoding and the legal read-latency range together with a helper
// used for the elaboration-time parameter check.
package param_dp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/param_dp_ram_rd_pipe.sv
// dp_ram_rd_pipe
// Read-side output pipeline of param_dp_ram. Carries the sampled read word,
// its valid flag and its collision flag through one or two register stages.
// Data registers load only on valid so rd_data holds its last value between
// reads; valid and collision bits are synchronously reset.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_valid   in   a read was accepted this cycle
//   in_data    in   word sampled for that read (DATA_W)
//   in_coll    in   that read hit the address written in the same cycle
//   rd_data    out  read data, held between reads (DATA_W)
//   rd_valid   out  one-cycle pulse marking new rd_data
//   collision  out  collision flag aligned with rd_valid
module dp_ram_rd_pipe
  import param_dp_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_coll,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              collision
);

  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  logic              s1_coll;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_coll  <= in_valid & in_coll;
      if (in_valid) begin
        s1_data <= in_data;
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rd_data   = s1_data;
      assign rd_valid  = s1_valid;
      assign collision = s1_coll;
    end else begin : g_lat2
      logic [DATA_W-1:0] s2_data;
      logic              s2_valid;
      logic              s2_coll;

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
          s2_coll  <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          s2_coll  <= s1_coll;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rd_data   = s2_data;
      assign rd_valid  = s2_valid;
      assign collision = s2_coll;
    end
  endgenerate

endmodule

// File: rtl/param_dp_ram.sv
// param_dp_ram
// Simple dual-port RAM (one write port, one read port, single clock) with a
// hardware clear sequencer that writes CLEAR_VAL to every entry after reset.
// User operations are ignored while busy is high.
//
// State table:
//   ST_CLEAR | sequencer writes CLEAR_VAL to mem[clr_addr], busy=1
//   ST_READY | normal read/write operation, busy=0
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   cs         in   chip select, gates both ports
//   wr_en      in   write request
//   wr_addr    in   write address (ADDR_W)
//   wr_data    in   write data (DATA_W)
//   rd_en      in   read request
//   rd_addr    in   read address (ADDR_W)
//   rd_data    out  read data, held between reads (DATA_W)
//   rd_valid   out  one-cycle pulse marking new rd_data
//   collision  out  read hit the address written in the same cycle
//   busy       out  clear sequence in progress
module param_dp_ram
  import param_dp_ram_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 4,
  parameter int                RD_LAT      = 1,
  parameter bit                WRITE_FIRST = 1'b0,
  parameter logic [DATA_W-1:0] CLEAR_VAL   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              collision,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  generate
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("param_dp_ram: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] clr_addr;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_fire;
  logic              coll_hit;
  logic [DATA_W-1:0] rd_word;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave CLEAR right after the last entry is written
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Output logic: write-port mux between sequencer and user, read gating
  always_comb begin
    busy      = 1'b1;
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = CLEAR_VAL;
    rd_fire   = 1'b0;
    coll_hit  = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      ST_READY: begin
        busy      = 1'b0;
        mem_we    = cs & wr_en;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        rd_fire   = cs & rd_en;
        coll_hit  = cs & rd_en & wr_en & (wr_addr == rd_addr);
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end

  // The reset term keeps the sequencer from writing while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Array read sees pre-edge contents (old data); write-first bypasses it.
  always_comb begin
    rd_word = mem[rd_addr];
    if (WRITE_FIRST && coll_hit) begin
      rd_word = wr_data;
    end
  end

  dp_ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_fire),
    .in_data   (rd_word),
    .in_coll   (coll_hit),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .collision (collision)
  );

endmodule

// File: tb/tb_param_dp_ram.sv
// Testbench for param_dp_ram. Two instances share one stimulus stream:
// dut_a (RD_LAT=1, read-old on collision) and dut_b (RD_LAT=2, write-first).
// A reference model (memory array, clear countdown and a queue of pending
// read results tagged with the cycle they are due) checks every cycle.
module tb_param_dp_ram;

  logic       clk;
  logic       reset;
  logic       cs;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;

  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic       collision_a, collision_b;
  logic       busy_a, busy_b;

  int tot = 0;
  int bad = 0;

  param_dp_ram #(
    .DATA_W(8), .ADDR_W(4), .RD_LAT(1), .WRITE_FIRST(1'b0), .CLEAR_VAL(8'hA5)
  ) dut_a (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .collision(collision_a), .busy(busy_a)
  );

  param_dp_ram #(
    .DATA_W(8), .ADDR_W(4), .RD_LAT(2), .WRITE_FIRST(1'b1), .CLEAR_VAL(8'hA5)
  ) dut_b (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .collision(collision_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [7:0] d;
    logic       c;
  } rec_t;

  logic [7:0] mmem [16];
  int         clr_left = 16;
  int         ncyc = 0;
  rec_t       qa[$];
  rec_t       qb[$];
  logic [7:0] last_a = 8'h00, last_b = 8'h00;
  logic       ev_a, ev_b, ec_a, ec_b;

  task automatic model_edge();
    logic [7:0] old;
    logic       c;
    rec_t       r;
    ncyc++;
    if (reset) begin
      clr_left = 16;
      qa.delete();
      qb.delete();
      last_a = 8'h00;
      last_b = 8'h00;
    end else if (clr_left > 0) begin
      mmem[16 - clr_left] = 8'hA5;
      clr_left--;
    end else begin
      if (cs && rd_en) begin
        old = mmem[rd_addr];
        c = wr_en && (wr_addr == rd_addr);
        r.due = ncyc;     r.d = old;               r.c = c; qa.push_back(r);
        r.due = ncyc + 1; r.d = c ? wr_data : old; r.c = c; qb.push_back(r);
      end
      if (cs && wr_en) mmem[wr_addr] = wr_data;
    end
    ev_a = 1'b0; ec_a = 1'b0; ev_b = 1'b0; ec_b = 1'b0;
    if (qa.size() > 0 && qa[0].due == ncyc) begin
      r = qa.pop_front(); ev_a = 1'b1; ec_a = r.c; last_a = r.d;
    end
    if (qb.size() > 0 && qb[0].due == ncyc) begin
      r = qb.pop_front(); ev_b = 1'b1; ec_b = r.c; last_b = r.d;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, ncyc, act, exp);
    end
  endtask

  task automatic check_model();
    chk("busy_a", 32'(busy_a), 32'(clr_left > 0));
    chk("busy_b", 32'(busy_b), 32'(clr_left > 0));
    chk("valid_a", 32'(rd_valid_a), 32'(ev_a));
    chk("valid_b", 32'(rd_valid_b), 32'(ev_b));
    chk("coll_a", 32'(collision_a), 32'(ec_a));
    chk("coll_b", 32'(collision_b), 32'(ec_b));
    chk("data_a", 32'(rd_data_a), 32'(last_a));
    chk("data_b", 32'(rd_data_b), 32'(last_b));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic we, input logic [3:0] wa,
                       input logic [7:0] wd, input logic re, input logic [3:0] ra);
    cs = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
  endtask

  // ---------------- directed vectors (dut_a expectations) ----------------
  typedef struct {
    logic       c;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic       ev;
    logic [7:0] ed;
    logic       ec;
  } vec_t;

  vec_t vt[11];

  int   n;
  int   vcnt;
  logic sv_v[5];
  logic [7:0] sv_d[5];

  initial begin
    vt[0]  = '{1'b1, 1'b1, 4'd7, 8'h77, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 4'd5, 8'h55, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 4'd4, 8'h11, 1'b1, 4'd7, 1'b1, 8'h77, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 1'b1, 8'h11, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 4'd5, 8'h99, 1'b1, 4'd5, 1'b1, 8'h55, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 8'h99, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 4'd5, 8'h00, 1'b1, 4'd5, 1'b0, 8'h00, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 8'h99, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 8'hA5, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 1'b1, 8'hA5, 1'b0};
    vt[10] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0};

    reset = 1'b1;
    idle();

    // Clear after reset, with ops attempted while busy
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_valid", 32'(rd_valid_a), 32'd0);
    chk("rst_data", 32'(rd_data_a), 32'd0);
    reset = 1'b0;
    n = 0;
    vcnt = 0;
    while (busy_a && n < 40) begin
      if (n < 2) drive(1'b1, 1'b1, 4'd2, 8'h3C, 1'b1, 4'd2);
      else idle();
      cycle();
      n++;
      if (rd_valid_a || rd_valid_b) vcnt++;
    end
    chk("busy_len", 32'(n), 32'd16);
    chk("no_valid_busy", 32'(vcnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
      cycle();
      chk("clear_rd", 32'(rd_data_a), 32'hA5);
    end
    idle();
    cycle();

    // Directed table
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].c, vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra);
      cycle();
      chk("vec_valid", 32'(rd_valid_a), 32'(vt[i].ev));
      if (vt[i].ev) begin
        chk("vec_data", 32'(rd_data_a), 32'(vt[i].ed));
        chk("vec_coll", 32'(collision_a), 32'(vt[i].ec));
      end
    end

    // RD_LAT=2 latency and throughput on dut_b
    drive(1'b1, 1'b1, 4'd0, 8'h10, 1'b0, 4'd0); cycle();
    drive(1'b1, 1'b1, 4'd1, 8'h21, 1'b0, 4'd0); cycle();
    drive(1'b1, 1'b1, 4'd2, 8'h32, 1'b0, 4'd0); cycle();
    idle(); cycle(); cycle();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(k));
      else idle();
      cycle();
      sv_v[k] = rd_valid_b;
      sv_d[k] = rd_data_b;
    end
    chk("lat2_v0", 32'(sv_v[0]), 32'd0);
    chk("lat2_v1", 32'(sv_v[1]), 32'd1);
    chk("lat2_v2", 32'(sv_v[2]), 32'd1);
    chk("lat2_v3", 32'(sv_v[3]), 32'd1);
    chk("lat2_v4", 32'(sv_v[4]), 32'd0);
    chk("lat2_d1", 32'(sv_d[1]), 32'h10);
    chk("lat2_d2", 32'(sv_d[2]), 32'h21);
    chk("lat2_d3", 32'(sv_d[3]), 32'h32);
    chk("lat2_hold", 32'(sv_d[4]), 32'h32);

    // Reset mid-clear at clear cycle 9
    reset = 1'b1; cycle();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin
      cycle();
      n++;
    end
    chk("busy_len_restart", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
      cycle();
      chk("restart_rd", 32'(rd_data_a), 32'hA5);
    end
    idle();
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), wa,
            8'($urandom), 1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 20; i++) cycle();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
